// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the matrix register-file loader.
package regfile_pkg;

    localparam int DEF_N       = 16;
    localparam int DEF_REGN    = 512;
    localparam int DEF_B_START = 256;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_loader_row_buf.sv
// Row assembly buffer: words land in a staging row, and the full row is
// committed to the output register so IN_DATA only changes on a row write.
module row_buf
    import regfile_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_wr,
    input  logic [$clog2(N)-1:0] i_idx,
    input  word_t                i_data,
    input  logic                 i_commit,
    output logic [N*32-1:0]      o_row
);

    logic [N*32-1:0] r_stage;
    logic [N*32-1:0] r_row;
    logic [N*32-1:0] w_merged;

    // The final word of a row is merged in so commit can happen on its acceptance cycle.
    always_comb begin
        w_merged = r_stage;
        if (i_wr) begin
            w_merged[i_idx*32 +: 32] = i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_stage <= '0;
            r_row   <= '0;
        end else begin
            if (i_wr) begin
                r_stage[i_idx*32 +: 32] <= i_data;
            end
            if (i_commit) begin
                r_row <= w_merged;
            end
        end
    end

    assign o_row = r_row;

endmodule

// File: rtl/regfile_loader.sv
// Streams one N x N matrix row-major into the A or B register-file region.
// Optional framing check on S_LAST is enabled by REGFILE_LOADER_LAST_CHECK_EN.
module regfile_loader
    import regfile_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int REGN    = DEF_REGN,
    parameter int B_START = DEF_B_START
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_start,
    input  logic                 i_mat_sel,
    input  word_t                i_s_data,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic                 i_s_last,
    output logic [N*32-1:0]      o_in_data,
    output logic [$clog2(N)-1:0] o_seq_datc,
    output logic                 o_wr_en,
    output logic                 o_wr_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output state_e               o_state
);

    localparam int              CW       = $clog2(N);
    localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);

    if (B_START != REGN / 2) begin : g_bad_cfg
        $error("regfile_loader: B_START must equal REGN/2");
    end

    state_e        r_state;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_seq;
    logic          r_wr_b;
    logic          w_accept;
    logic          w_row_done;

    // Stream handshake: a word transfers on a rising edge where S_VALID and
    // S_READY are both 1; S_READY is high only in FILL, S_DATA is don't-care otherwise.
    assign w_accept   = (r_state == ST_FILL) && i_s_valid;
    assign w_row_done = w_accept && (r_col == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_seq   <= '0;
            r_wr_b  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_FILL;
                        r_wr_b  <= i_mat_sel;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_col <= r_col + 1'b1;
                        if (r_col == LAST_IDX) begin
                            r_state <= ST_WRITE;
                            r_seq   <= r_row;
                        end
                    end
                end
                ST_WRITE: begin
                    r_row   <= r_row + 1'b1;
                    r_state <= (r_row == LAST_IDX) ? ST_FIN : ST_FILL;
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    row_buf #(.N(N)) u_row_buf (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_wr     (w_accept),
        .i_idx    (r_col),
        .i_data   (i_s_data),
        .i_commit (w_row_done),
        .o_row    (o_in_data)
    );

`ifdef REGFILE_LOADER_LAST_CHECK_EN
    logic r_err;
    logic w_last_word;

    assign w_last_word = (r_row == LAST_IDX) && (r_col == LAST_IDX);

    // Sticky: loading carries on after a framing error; only reset or a new START clears it.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_err <= 1'b0;
        end else if (w_accept && (i_s_last != w_last_word)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_last;
    assign w_unused_last = i_s_last;
    assign o_err         = 1'b0;
`endif

    assign o_s_ready  = (r_state == ST_FILL);
    assign o_wr_en    = (r_state == ST_WRITE);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_FIN);
    assign o_seq_datc = r_seq;
    assign o_wr_b     = r_wr_b;
    assign o_state    = r_state;

endmodule

// File: tb/tb_regfile_loader.sv
// Self-checking bench for regfile_loader: table of whole-matrix loads plus a
// mid-load reset sequence; rows are checked against a queue of expected words.
module tb_regfile_loader;
    import regfile_pkg::*;

    localparam int N     = 16;
    localparam int W     = N * 32;
    localparam int WORDS = N * N;

    logic           clk = 1'b0;
    logic           rstn;
    logic           i_start;
    logic           i_mat_sel;
    logic [31:0]    i_s_data;
    logic           i_s_valid;
    logic           o_s_ready;
    logic           i_s_last;
    logic [W-1:0]   o_in_data;
    logic [3:0]     o_seq_datc;
    logic           o_wr_en;
    logic           o_wr_b;
    logic           o_busy;
    logic           o_done;
    logic           o_err;
    state_e         o_state;

    regfile_loader #(.N(N), .REGN(512), .B_START(256)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (i_start),
        .i_mat_sel  (i_mat_sel),
        .i_s_data   (i_s_data),
        .i_s_valid  (i_s_valid),
        .o_s_ready  (o_s_ready),
        .i_s_last   (i_s_last),
        .o_in_data  (o_in_data),
        .o_seq_datc (o_seq_datc),
        .o_wr_en    (o_wr_en),
        .o_wr_b     (o_wr_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        mat_sel;
        int          mode;       // 0 constant, 1 ramp, 2 hashed
        logic [31:0] val;
        bit          gaps;
        bit          start_mid;
        int          last_word;  // word index carrying S_LAST
        bit          check_lat;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    // Monitor / scoreboard state
    int           mon_row;
    int           n_wr;
    int           hold_err;
    bit           done_seen;
    int           done_cyc;
    logic         err_at_done;
    logic         exp_wr_b;
    logic [W-1:0] last_row;
    logic [3:0]   last_seq;

    int sent;
    bit vld_t;
    int st_cyc;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        case (v.mode)
            0:       word_of = v.val;
            1:       word_of = 32'(i);
            default: word_of = (32'(i) * 32'h9E3779B1) ^ v.val;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_data"}, o_in_data, '0);
        check({tag, "_seq"},     W'(o_seq_datc), '0);
        check({tag, "_wr_en"},   W'(o_wr_en), '0);
        check({tag, "_wr_b"},    W'(o_wr_b), '0);
        check({tag, "_busy"},    W'(o_busy), '0);
        check({tag, "_done"},    W'(o_done), '0);
        check({tag, "_err"},     W'(o_err), '0);
        check({tag, "_ready"},   W'(o_s_ready), '0);
        check({tag, "_state"},   W'(o_state), W'(ST_IDLE));
    endtask

    always @(negedge clk) begin
        logic [W-1:0] exp_row;
        if (o_wr_en) begin
            check("row_queue_depth", W'(exp_q.size() >= N), W'(1));
            exp_row = '0;
            for (int c = 0; c < N; c++) begin
                if (exp_q.size() > 0) exp_row[c*32 +: 32] = exp_q.pop_front();
            end
            check("row_data", o_in_data, exp_row);
            check("row_idx", W'(o_seq_datc), W'(mon_row));
            check("row_wr_b", W'(o_wr_b), W'(exp_wr_b));
            check("ready_in_write", W'(o_s_ready), W'(0));
            last_row = o_in_data;
            last_seq = o_seq_datc;
            mon_row++;
            n_wr++;
        end else if (o_busy && n_wr > 0) begin
            if (o_in_data !== last_row || o_seq_datc !== last_seq || o_wr_b !== exp_wr_b)
                hold_err++;
        end
        if (o_done && !done_seen) begin
            done_seen   = 1'b1;
            done_cyc    = cyc;
            err_at_done = o_err;
        end
    end

    task automatic start_load(input vec_t v);
        mon_row   = 0;
        n_wr      = 0;
        hold_err  = 0;
        done_seen = 1'b0;
        sent      = 0;
        vld_t     = 1'b0;
        exp_wr_b  = v.mat_sel;
        @(negedge clk);
        i_start   = 1'b1;
        i_mat_sel = v.mat_sel;
        st_cyc    = cyc;
        @(negedge clk);
        i_start   = 1'b0;
        i_mat_sel = ~v.mat_sel;
        check("busy_after_start", W'(o_busy), W'(1));
        check("err_clear_on_start", W'(o_err), W'(0));
    endtask

    task automatic stream(input vec_t v, input int n);
        int guard = 0;
        logic [31:0] w;
        while (sent < n && guard < 4 * WORDS) begin
            vld_t     = v.gaps ? ~vld_t : 1'b1;
            w         = word_of(v, sent);
            i_s_valid = vld_t;
            i_s_data  = vld_t ? w : $urandom;
            i_s_last  = (sent == v.last_word);
            i_start   = v.start_mid && (sent == 2 * N + 5);
            if (vld_t && o_s_ready) begin
                exp_q.push_back(w);
                sent++;
            end
            @(negedge clk);
            guard++;
        end
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
        i_start   = 1'b0;
        check("stream_complete", W'(sent), W'(n));
    endtask

    task automatic finish_load(input vec_t v);
        int   g = 0;
        logic exp_err;
`ifdef REGFILE_LOADER_LAST_CHECK_EN
        exp_err = (v.last_word != WORDS - 1);
`else
        exp_err = 1'b0;
`endif
        while (!done_seen && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", W'(done_seen), W'(1));
        check("write_count", W'(n_wr), W'(N));
        check("hold_between_writes", W'(hold_err), W'(0));
        check("err_at_done", W'(err_at_done), W'(exp_err));
        check("queue_drained", W'(exp_q.size()), W'(0));
        if (v.check_lat) check("done_latency", W'(done_cyc - st_cyc), W'(273));
        @(negedge clk);
        check("idle_after_done", W'(o_busy), W'(0));
        check("err_sticky_after_done", W'(o_err), W'(exp_err));
    endtask

    initial begin
        vec_t v_rst;

        vecs[0] = '{mat_sel: 1'b0, mode: 0, val: 32'd5, gaps: 1'b0, start_mid: 1'b0, last_word: WORDS - 1, check_lat: 1'b1};
        vecs[1] = '{mat_sel: 1'b1, mode: 0, val: 32'd9, gaps: 1'b1, start_mid: 1'b0, last_word: WORDS - 1, check_lat: 1'b0};
        vecs[2] = '{mat_sel: 1'b0, mode: 1, val: 32'd0, gaps: 1'b0, start_mid: 1'b1, last_word: WORDS - 1, check_lat: 1'b1};
        vecs[3] = '{mat_sel: 1'b1, mode: 2, val: $urandom, gaps: 1'b1, start_mid: 1'b0, last_word: 100, check_lat: 1'b0};
        vecs[4] = '{mat_sel: 1'b0, mode: 0, val: 32'd7, gaps: 1'b0, start_mid: 1'b0, last_word: WORDS - 1, check_lat: 1'b1};
        vecs[5] = '{mat_sel: 1'b1, mode: 1, val: 32'd0, gaps: 1'b0, start_mid: 1'b1, last_word: WORDS + 44, check_lat: 1'b1};
        v_rst   = '{mat_sel: 1'b1, mode: 2, val: 32'h33, gaps: 1'b0, start_mid: 1'b0, last_word: WORDS - 1, check_lat: 1'b0};

        rstn      = 1'b0;
        i_start   = 1'b0;
        i_mat_sel = 1'b0;
        i_s_data  = '0;
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
        mon_row   = 0;
        n_wr      = 0;
        hold_err  = 0;
        done_seen = 1'b0;
        exp_wr_b  = 1'b0;
        last_row  = '0;
        last_seq  = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Reset landing mid-FILL at row 3, column 7: partial row dropped, no write.
        start_load(v_rst);
        stream(v_rst, 3 * N + 7);
        rstn      = 1'b0;
        i_s_valid = 1'b1;
        i_s_data  = $urandom;
        @(negedge clk);
        check_idle("midload_reset_c1");
        @(negedge clk);
        check_idle("midload_reset_c2");
        rstn      = 1'b1;
        i_s_valid = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("no_write_after_reset", W'(n_wr), W'(3));
        check("idle_after_reset", W'(o_state), W'(ST_IDLE));

        for (int k = 0; k < 6; k++) begin
            start_load(vecs[k]);
            stream(vecs[k], WORDS);
            finish_load(vecs[k]);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_loader.md
REGFILE_LOADER -- requirements
Module: regfile_loader

Interface
REQ-001 Parameter N, 16: words per matrix row; rows per matrix; power of two, at least 2.
REQ-002 Parameter REGN, 512: register-file depth in words; carried for address checking only.
REQ-003 Parameter B_START, 256: base word offset of matrix B; SHALL equal REGN/2.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RSTN  input  1  reset, synchronous and active-low.
REQ-006 START  input  1  one-cycle request to load one N x N matrix.
REQ-007 MAT_SEL  input  1  target matrix: 0 = A, 1 = B; sampled with START.
REQ-008 S_DATA  input  32  streamed word, row-major.
REQ-009 S_VALID  input  1  S_DATA valid.
REQ-010 S_READY  output  1  loader accepts S_DATA this cycle.
REQ-011 S_LAST  input  1  marks final word of the matrix; used only when the configuration macro is defined.
REQ-012 IN_DATA  output  N x 32  packed row to the register file; index 0 is the first word received.
REQ-013 SEQ_DATC  output  $clog2(N)  row index of IN_DATA.
REQ-014 WR_EN  output  1  one-cycle row-write strobe.
REQ-015 WR_B  output  1  row targets matrix B region (offset B_START).
REQ-016 BUSY  output  1  load in progress.
REQ-017 DONE  output  1  one-cycle pulse after the last row write.
REQ-018 ERR  output  1  sticky S_LAST framing error.

Function
REQ-019 FSM states SHALL be IDLE, FILL, WRITE, FIN.
REQ-020 IDLE: on START=1, latch MAT_SEL into WR_B, clear the column and row counters, go to FILL; BUSY=1 from the next cycle.
REQ-021 FILL: S_READY=1; a word is accepted when S_VALID and S_READY are both 1, stored at the current column index, and the column counter increments.
REQ-022 On acceptance at column N-1, go to WRITE; the column counter wraps to 0.
REQ-023 WRITE (exactly one cycle): WR_EN=1, S_READY=0, IN_DATA holds the full row, SEQ_DATC holds the current row index.
REQ-024 After WRITE, the row counter increments; if the row was N-1, go to FIN, else return to FILL.
REQ-025 FIN (one cycle): DONE=1, BUSY stays 1; next state IDLE.
REQ-026 Latency: WR_EN SHALL assert in the cycle after the Nth word of a row is accepted.
REQ-027 Throughput: one row per N+1 cycles with S_VALID held high.
REQ-028 START outside IDLE SHALL be ignored; MAT_SEL changes mid-load have no effect.
REQ-029 S_VALID=0 in FILL stalls the FSM with no state change; S_DATA is ignored whenever S_READY=0.
REQ-030 IN_DATA, SEQ_DATC and WR_B SHALL hold their values between WR_EN pulses.

Reset
REQ-031 RSTN=0 at a clock edge, including mid-load, SHALL force the following: state IDLE; counters 0; IN_DATA all zero; SEQ_DATC, WR_EN, WR_B, BUSY, DONE, ERR, S_READY all 0.
REQ-032 A partially received row is discarded and no WR_EN is issued.

Configuration
REQ-033 Macro REGFILE_LOADER_LAST_CHECK_EN, when defined: ERR sets if S_LAST=1 on any accepted word other than the N*N-th, or S_LAST=0 on the N*N-th; loading continues regardless; ERR clears only on reset or on an accepted START.
REQ-034 Macro REGFILE_LOADER_LAST_CHECK_EN, when undefined: S_LAST is ignored and ERR is tied to 0.

Structure
REQ-035 The shared package regfile_pkg SHALL hold the FSM state enum (IDLE/FILL/WRITE/FIN), the 32-bit word typedef, and the default N/REGN/B_START constants.
REQ-036 The sub-module row_buf (N x 32 indexed write buffer with synchronous clear) SHALL hold IN_DATA; the FSM and counters stay in regfile_loader.

Verification
REQ-037 Reset: RSTN=0 for 2 cycles mid-FILL (row 3, col 7) -> all outputs 0, state IDLE, no WR_EN.
REQ-038 Load A: START with MAT_SEL=0, stream 256 words of value 5, S_VALID=1 -> 16 WR_EN pulses, SEQ_DATC 0..15, WR_B=0, each IN_DATA all 5, DONE in cycle 273 after START.
REQ-039 Load B with gaps: MAT_SEL=1, words 9, S_VALID toggled every cycle -> 16 writes with WR_B=1, word order preserved, S_READY=0 during every WRITE cycle.
REQ-040 START asserted during FILL of row 2 -> ignored; WR_B unchanged, row sequence uninterrupted.
REQ-041 With the macro defined, S_LAST on word 100 -> ERR=1 persisting through DONE; the next START clears ERR.
REQ-042 Word ordering: stream values 0..255 -> row r, index c equals 16r+c.
